mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single unified instruction/data memory of the multicycle ARM core.
- Port 0 is the core's memory interface, driven by the main FSM's fetch and LDR/STR states.
- Port 1 is the program loader/debug port.
- Grants one requester at a time with round-robin fairness, holds the memory request until the memory signals ready, returns read data and a completion pulse, and aborts hung accesses with an error after a bounded wait.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the unified
// instruction/data memory: core on port 0, loader/debug on port 1.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          owner,
    output logic          busy
);

    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          win;
    logic          timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // On a tie the port that was not granted last time wins.
    always_comb begin
        next_state = state;
        win        = 1'b0;
        timeout    = 1'b0;
        if (req0 && req1) win = ~owner;
        else              win = req1;
        timeout = (WAIT_MAX != 0) && (cnt == CNT_LAST);
        case (state)
            IDLE:    if (req0 || req1) next_state = BUSY;
            BUSY:    if (mem_ready || timeout) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            owner     <= 1'b1;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        mem_we    <= win ? we1 : we0;
                        mem_addr  <= win ? addr1 : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
                        owner     <= win;
                        mem_en    <= 1'b1;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    // A ready in the last allowed cycle completes normally, not as a timeout.
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        if (!mem_we) begin
                            if (owner) rdata1 <= mem_rdata;
                            else       rdata0 <= mem_rdata;
                        end
                        ack0 <= ~owner;
                        ack1 <= owner;
                        err  <= 1'b0;
                    end else if (timeout) begin
                        mem_en <= 1'b0;
                        ack0   <= ~owner;
                        ack1   <= owner;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    err  <= 1'b0;
                end
                default: begin
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a transaction-timing reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, ack0, req1, we1, ack1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic          err, mem_en, mem_we, mem_ready, owner, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1, mrd;
        logic        own;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata, rd0, rd1;
    } vec_t;

    vec_t vecs[8];

    // One zero-wait transaction per vector, starting from an IDLE cycle.
    task automatic apply_vec(input vec_t v);
        req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
        addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
        mem_ready = 1'b1; mem_rdata = v.mrd;
        @(negedge clk);
        chk("vec_busy_en", mem_en, 1);
        chk("vec_addr", mem_addr, v.addr);
        chk("vec_we", mem_we, v.we);
        chk("vec_wdata", mem_wdata, v.wdata);
        chk("vec_owner", owner, v.own);
        chk("vec_busy", busy, 1);
        chk("vec_early_ack", ack0 | ack1, 0);
        @(negedge clk);
        chk("vec_ack0", ack0, !v.own);
        chk("vec_ack1", ack1, v.own);
        chk("vec_err", err, 0);
        chk("vec_done_en", mem_en, 0);
        chk("vec_rdata0", rdata0, v.rd0);
        chk("vec_rdata1", rdata1, v.rd1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("vec_idle_busy", busy, 0);
        chk("vec_idle_ack", ack0 | ack1, 0);
    endtask

    // Reference model state for the random phase
    logic        tx_v, tx_p, tx_we, last_own, to;
    logic [31:0] tx_addr, tx_wd, tx_rd;
    int          tx_start, tx_w, weff, free_at;
    logic [31:0] exp_rd[2];
    logic        rq[2], wq[2];
    logic [31:0] aq[2], dq[2];
    logic        e_en, e_ack, e_busy;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h80, 32'h0, 32'h0, 32'hE3A01005,
                    1'b0, 32'h10, 1'b0, 32'h0, 32'hE3A01005, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h24, 32'hAAAA0000, 32'hBBBB0000, 32'h11112222,
                    1'b1, 32'h24, 1'b0, 32'hBBBB0000, 32'hE3A01005, 32'h11112222};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h34, 32'hCAFEF00D, 32'h12345678, 32'h55555555,
                    1'b0, 32'h30, 1'b1, 32'hCAFEF00D, 32'hE3A01005, 32'h11112222};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h40, 32'h0, 32'hDEADBEEF, 32'h66666666,
                    1'b1, 32'h40, 1'b1, 32'hDEADBEEF, 32'hE3A01005, 32'h11112222};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h48, 32'h0, 32'h0, 32'h77777777,
                    1'b1, 32'h48, 1'b0, 32'h0, 32'hE3A01005, 32'h77777777};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h54, 32'h1, 32'h2, 32'h88888888,
                    1'b0, 32'h50, 1'b0, 32'h1, 32'h88888888, 32'h77777777};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h58, 32'h5C, 32'h3, 32'h0, 32'h99999999,
                    1'b0, 32'h58, 1'b0, 32'h3, 32'h99999999, 32'h77777777};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h5C, 32'h60, 32'h0, 32'h4, 32'hA5A5A5A5,
                    1'b1, 32'h60, 1'b0, 32'h4, 32'h99999999, 32'hA5A5A5A5};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ack", {ack0, ack1, err}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_owner", owner, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // Fairness: both ports request continuously from reset.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h100; addr1 = 32'h200;
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("fair_ack0", ack0, (k % 3 == 2) && ((k / 3) % 2 == 0));
            chk("fair_ack1", ack1, (k % 3 == 2) && ((k / 3) % 2 == 1));
            chk("fair_overlap", ack0 & ack1, 0);
            if (k % 3 == 1) begin
                chk("fair_owner", owner, (k / 3) % 2);
                chk("fair_addr", mem_addr, ((k / 3) % 2 == 1) ? 32'h200 : 32'h100);
            end
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("fair_rdata0", rdata0, 32'h0BADF00D);
        chk("fair_rdata1", rdata1, 32'h0BADF00D);
        chk("fair_idle", busy, 0);

        // Port 1 write with three wait states.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hDEADBEEF;
        mem_rdata = 32'h13579BDF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_en", mem_en, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, 32'h40);
            chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
            chk("wr_early_ack", ack0 | ack1, 0);
            if (i == 3) mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("wr_ack1", ack1, 1);
        chk("wr_ack0", ack0, 0);
        chk("wr_err", err, 0);
        chk("wr_done_en", mem_en, 0);
        chk("wr_rdata1", rdata1, 32'h0BADF00D);
        req1 = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("wr_idle_ack", ack1, 0);
        chk("wr_idle_busy", busy, 0);

        // Port 0 read that never completes; address changes mid-access.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_en", mem_en, 1);
            chk("to_addr", mem_addr, 32'h10);
            chk("to_early_ack", ack0 | err, 0);
            if (i == 0) addr0 = 32'h20;
        end
        @(negedge clk);
        chk("to_ack0", ack0, 1);
        chk("to_err", err, 1);
        chk("to_done_en", mem_en, 0);
        chk("to_rdata0", rdata0, 32'h0BADF00D);
        chk("to_hold_addr", mem_addr, 32'h10);
        req0 = 1'b0;
        @(negedge clk);
        chk("to_idle", {busy, ack0, err, mem_en}, 0);

        // Reset during a port 1 access with both requests pending.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h90; addr1 = 32'h80; mem_ready = 1'b0;
        @(negedge clk);
        chk("mr_owner1", owner, 1);
        chk("mr_addr1", mem_addr, 32'h80);
        @(negedge clk);
        chk("mr_busy_en", mem_en, 1);
        reset = 1'b1;
        #1;
        chk("mr_async_en", mem_en, 0);
        chk("mr_async_ack", ack0 | ack1, 0);
        chk("mr_async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("mr_owner0", owner, 0);
        chk("mr_addr0", mem_addr, 32'h90);
        chk("mr_no_ack1", ack1, 0);
        @(negedge clk);
        chk("mr_ack0", ack0, 1);
        chk("mr_ack1", ack1, 0);
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("mr_idle", {busy, ack0, ack1}, 0);

        // Randomized traffic against the transaction-timing model.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tx_v = 1'b0; tx_p = 1'b0; tx_we = 1'b0; tx_addr = '0; tx_wd = '0; tx_rd = '0;
        tx_start = 0; tx_w = 0; free_at = 0; last_own = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; wq[p] = 1'b0; aq[p] = '0; dq[p] = '0;
        end
        for (int k = 0; k < 700; k++) begin
            to     = (tx_w >= WM);
            weff   = to ? WM - 1 : tx_w;
            e_en   = tx_v && (k >= tx_start + 1) && (k <= tx_start + 1 + weff);
            e_ack  = tx_v && (k == tx_start + 2 + weff);
            e_busy = tx_v && (k >= tx_start + 1) && (k <= tx_start + 2 + weff);
            if (e_ack && !to && !tx_we) exp_rd[tx_p] = tx_rd;

            chk("rnd_mem_en", mem_en, e_en);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_ack0", ack0, e_ack && !tx_p);
            chk("rnd_ack1", ack1, e_ack && tx_p);
            chk("rnd_err", err, e_ack && to);
            chk("rnd_mem_addr", mem_addr, tx_v ? tx_addr : 32'h0);
            chk("rnd_mem_we", mem_we, tx_v ? tx_we : 1'b0);
            chk("rnd_mem_wdata", mem_wdata, tx_v ? tx_wd : 32'h0);
            chk("rnd_rdata0", rdata0, exp_rd[0]);
            chk("rnd_rdata1", rdata1, exp_rd[1]);
            chk("rnd_owner", owner, last_own);

            for (int p = 0; p < 2; p++) begin
                if (e_ack && (int'(tx_p) == p)) begin
                    rq[p] = ($urandom_range(0, 1) == 1);
                    wq[p] = ($urandom_range(0, 1) == 1);
                    aq[p] = $urandom; dq[p] = $urandom;
                end else if (!rq[p]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        rq[p] = 1'b1;
                        wq[p] = ($urandom_range(0, 1) == 1);
                        aq[p] = $urandom; dq[p] = $urandom;
                    end
                end else if ($urandom_range(0, 9) < 2) begin
                    wq[p] = ($urandom_range(0, 1) == 1);
                    aq[p] = $urandom; dq[p] = $urandom;
                end
            end
            req0 = rq[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0];
            req1 = rq[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1];

            if (tx_v && !to && (k == tx_start + 1 + tx_w)) begin
                mem_ready = 1'b1; mem_rdata = tx_rd;
            end else if (e_en) begin
                mem_ready = 1'b0; mem_rdata = $urandom;
            end else begin
                mem_ready = ($urandom_range(0, 1) == 1); mem_rdata = $urandom;
            end

            if ((k >= free_at) && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) tx_p = ~last_own;
                else                tx_p = rq[1];
                tx_v     = 1'b1;
                tx_we    = wq[tx_p];
                tx_addr  = aq[tx_p];
                tx_wd    = dq[tx_p];
                tx_rd    = $urandom;
                tx_start = k;
                tx_w     = int'($urandom_range(0, 5));
                last_own = tx_p;
                free_at  = k + 3 + ((tx_w >= WM) ? WM - 1 : tx_w);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
